// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers
// used by the column-serial SubBytes/ShiftRows stage.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int BYTE_W  = 8;
    localparam int NB      = 4;

    localparam logic [7:0] GF_POLY = 8'h1B;
    localparam logic [7:0] AFF_C   = 8'h63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse; 0 maps to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x,
                                        input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3)
                 ^ rotl(a, 4) ^ AFF_C;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
    endfunction

    // Source column for row r when producing output column c
    function automatic logic [1:0] src_col(input logic [1:0] c,
                                           input logic [1:0] r,
                                           input bit inv);
        return inv ? (c - r) : (c + r);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: forward (inverse then affine) or
// inverse (inverse affine then inverse) selected by ENC_DEC.
module aes_sbox
    import aes_pkg::*;
#(
    parameter bit ENC_DEC = 1'b0
) (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    always_comb begin
        if (ENC_DEC) out_byte = gf_inv(inv_affine(in_byte));
        else         out_byte = affine(gf_inv(in_byte));
    end

endmodule

// File: rtl/sub_shift_rows_seq.sv
// Column-serial SubBytes + ShiftRows: one output column per
// cycle through 4 S-boxes, 4 cycles per 128-bit block.
module sub_shift_rows_seq
    import aes_pkg::*;
#(
    parameter bit ENC_DEC = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:STATE_W-1]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:STATE_W-1]   out_data,
    output logic                 busy
);

    fsm_t               state_q, state_d;
    logic [1:0]         col_cnt_q, col_cnt_d;
    logic [0:STATE_W-1] din_q, din_d;
    logic [0:STATE_W-1] dout_q, dout_d;

    logic [7:0] sbox_in  [NB];
    logic [7:0] sbox_out [NB];

    // Row r of the current column reads from a rotated column
    always_comb begin
        for (int r = 0; r < NB; r++) begin
            sbox_in[r] = din_q[BYTE_W * (NB * int'(
                src_col(col_cnt_q, 2'(r), ENC_DEC)) + r) +: BYTE_W];
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_sbox
        aes_sbox #(.ENC_DEC(ENC_DEC)) u_sbox (
            .in_byte  (sbox_in[g]),
            .out_byte (sbox_out[g])
        );
    end

    assign in_ready  = (state_q == ST_IDLE) ||
                       ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_PROC);
    assign out_data  = dout_q;

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        din_d     = din_q;
        dout_d    = dout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d   = ST_PROC;
                    din_d     = in_data;
                    col_cnt_d = 2'd0;
                end
            end
            ST_PROC: begin
                for (int r = 0; r < NB; r++) begin
                    dout_d[BYTE_W * (NB * int'(col_cnt_q) + r)
                           +: BYTE_W] = sbox_out[r];
                end
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d   = ST_PROC;
                        din_d     = in_data;
                        col_cnt_d = 2'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            col_cnt_q <= 2'd0;
            din_q     <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
        end
    end

endmodule

// File: tb/tb_sub_shift_rows_seq.sv
// Bench for sub_shift_rows_seq: forward and inverse instances
// checked against a table-driven SubBytes/ShiftRows model.
module tb_sub_shift_rows_seq;

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] FIPS_IN  =
        128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT =
        128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic clk = 1'b0;
    logic reset_n;
    logic [1:0] in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0][127:0] in_data, out_data;

    logic [7:0] sbox_f [256];
    logic [7:0] sbox_i [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_shift_rows_seq #(.ENC_DEC(1'b0)) u_fwd (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .busy      (busy[0])
    );

    sub_shift_rows_seq #(.ENC_DEC(1'b1)) u_inv (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .busy      (busy[1])
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Byte b sits at bits [127-8b -: 8]; column c = bytes 4c..4c+3
    function automatic logic [127:0] ref_ssr(input logic [127:0] d,
                                             input int m);
        logic [127:0] res;
        logic [7:0]   ib;
        int           s;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s  = (m == 1) ? (c - r + 4) % 4 : (c + r) % 4;
                ib = d[127 - 8 * (4 * s + r) -: 8];
                res[127 - 8 * (4 * c + r) -: 8] =
                    (m == 1) ? sbox_i[ib] : sbox_f[ib];
            end
        end
        return res;
    endfunction

    task automatic run_block(input int m, input logic [127:0] d,
                             input logic [127:0] exp,
                             input string tag);
        int n;
        n = 0;
        while (!in_ready[m] && n < 50) begin
            tick();
            n++;
        end
        in_valid[m] = 1'b1;
        in_data[m]  = d;
        chk({tag, " in_ready"}, 128'(in_ready[m]), 128'd1);
        tick();
        in_valid[m] = 1'b0;
        in_data[m]  = rnd128();
        n = 1;
        while (!out_valid[m] && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'd5);
        chk({tag, " data"}, out_data[m], exp);
        tick();
        chk({tag, " one_cycle"}, 128'(out_valid[m]), 128'd0);
    endtask

    task automatic run_stream(input int m);
        logic [127:0] blk [8];
        logic [127:0] exq [$];
        int sent, got, cyc, last;
        logic hs;
        for (int i = 0; i < 8; i++) begin
            blk[i] = rnd128();
            exq.push_back(ref_ssr(blk[i], m));
        end
        sent = 0; got = 0; cyc = 0; last = 0;
        out_ready[m] = 1'b1;
        in_valid[m]  = 1'b1;
        in_data[m]   = blk[0];
        while (got < 8 && cyc < 200) begin
            hs = in_valid[m] & in_ready[m];
            if (out_valid[m]) begin
                chk($sformatf("stream%0d blk%0d", m, got),
                    out_data[m], exq.pop_front());
                if (got > 0)
                    chk($sformatf("stream%0d gap%0d", m, got),
                        128'(cyc - last), 128'd5);
                last = cyc;
                got++;
            end
            tick();
            cyc++;
            if (hs) begin
                sent++;
                if (sent < 8) in_data[m] = blk[sent];
                else          in_valid[m] = 1'b0;
            end
        end
        chk($sformatf("stream%0d count", m), 128'(got), 128'd8);
        for (int i = 0; i < 8; i++) begin
            if (out_valid[m])
                chk($sformatf("stream%0d extra", m),
                    128'(out_valid[m]), 128'd0);
            tick();
        end
    endtask

    initial begin
        logic [0:2047] tbl;
        logic [127:0]  d, e;
        int            n, extra;

        tbl = SBOX_TBL;
        for (int i = 0; i < 256; i++) sbox_f[i] = tbl[8 * i +: 8];
        for (int i = 0; i < 256; i++) sbox_i[sbox_f[i]] = 8'(i);

        reset_n   = 1'b0;
        in_valid  = '0;
        out_ready = 2'b11;
        in_data   = '0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst%0d in_ready", m),
                128'(in_ready[m]), 128'd1);
            chk($sformatf("rst%0d out_valid", m),
                128'(out_valid[m]), 128'd0);
            chk($sformatf("rst%0d busy", m), 128'(busy[m]), 128'd0);
            chk($sformatf("rst%0d out_data", m), out_data[m], 128'd0);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        run_block(0, FIPS_IN, FIPS_OUT, "fips_fwd");
        run_block(1, FIPS_OUT, FIPS_IN, "fips_inv");
        run_block(0, 128'd0, {16{8'h63}}, "zero_fwd");
        run_block(1, {16{8'h63}}, 128'd0, "x63_inv");
        for (int i = 0; i < 4; i++) begin
            d = rnd128();
            run_block(0, d, ref_ssr(d, 0), "rnd_fwd");
            d = rnd128();
            run_block(1, d, ref_ssr(d, 1), "rnd_inv");
        end

        // Backpressure on the forward instance
        out_ready[0] = 1'b0;
        d = rnd128();
        e = ref_ssr(d, 0);
        in_valid[0] = 1'b1;
        in_data[0]  = d;
        tick();
        in_valid[0] = 1'b0;
        n = 1;
        while (!out_valid[0] && n < 20) begin
            tick();
            n++;
        end
        chk("bp latency", 128'(n), 128'd5);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = (i == 3 || i == 4);
            in_data[0]  = rnd128();
            #1;
            chk("bp stable", out_data[0], e);
            chk("bp in_ready", 128'(in_ready[0]), 128'd0);
            chk("bp out_valid", 128'(out_valid[0]), 128'd1);
            tick();
        end
        in_valid[0] = 1'b0;
        chk("bp hold", out_data[0], e);
        chk("bp no_accept", 128'(busy[0]), 128'd0);
        d = rnd128();
        in_data[0]   = d;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        chk("bp b2b in_ready", 128'(in_ready[0]), 128'd1);
        tick();
        in_valid[0] = 1'b0;
        chk("bp b2b busy", 128'(busy[0]), 128'd1);
        n = 1;
        while (!out_valid[0] && n < 20) begin
            tick();
            n++;
        end
        chk("bp b2b latency", 128'(n), 128'd5);
        chk("bp b2b data", out_data[0], ref_ssr(d, 0));
        tick();

        run_stream(0);
        run_stream(1);

        // Reset during PROC discards the block in flight
        in_valid[0] = 1'b1;
        in_data[0]  = rnd128();
        tick();
        in_valid[0] = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("abort in_ready", 128'(in_ready[0]), 128'd1);
        chk("abort out_valid", 128'(out_valid[0]), 128'd0);
        chk("abort busy", 128'(busy[0]), 128'd0);
        chk("abort out_data", out_data[0], 128'd0);
        tick();
        reset_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid[0] || busy[0]) extra++;
            tick();
        end
        chk("abort no_output", 128'(extra), 128'd0);
        run_block(0, FIPS_IN, FIPS_OUT, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
